// File: rtl/gray_pkg.sv
// Shared Gray/binary conversion helpers and terminal values for the Gray counter family.
// Functions work on a fixed maximum width; callers pass the live width and slice the result.
package gray_pkg;

   localparam int                    GRAY_MAX_W = 32;
   localparam logic [GRAY_MAX_W-1:0] GRAY_ZERO  = '0;
   localparam logic [GRAY_MAX_W-1:0] GRAY_ONES  = '1;

   function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b,
                                                      input int                    w);
      logic [GRAY_MAX_W-1:0] g;
      g = b ^ (b >> 1);
      return g & (GRAY_ONES >> (GRAY_MAX_W - w));
   endfunction

   // Prefix XOR from the MSB of the live width down to bit 0.
   function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g,
                                                      input int                    w);
      logic [GRAY_MAX_W-1:0] b;
      logic                  p;
      b = '0;
      p = 1'b0;
      for (int i = GRAY_MAX_W - 1; i >= 0; i--) begin
         if (i < w) begin
            p    = p ^ g[i];
            b[i] = p;
         end
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_code_counter_n_if.sv
// Control and result signals of the N-bit Gray counter, grouped for master/slave use.
interface gray_code_counter_n_if #(
   parameter int WIDTH = 3
);
   logic             en;
   logic             up;
   logic             load;
   logic [WIDTH-1:0] load_gray;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] count_bin;
   logic             wrap;

   modport master (
      output en, up, load, load_gray,
      input  count, count_bin, wrap
   );

   modport slave (
      input  en, up, load, load_gray,
      output count, count_bin, wrap
   );
endinterface

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary converter; also reused by Gray-pointer synchronisers.
module gray2bin_conv
   import gray_pkg::*;
#(
   parameter int WIDTH = 3
) (
   input  logic [WIDTH-1:0] gray_i,
   output logic [WIDTH-1:0] bin_o
);

   logic [GRAY_MAX_W-1:0] b_ext;
   logic                  unused_hi;

   assign b_ext     = gray2bin(GRAY_MAX_W'(gray_i), WIDTH);
   assign bin_o     = b_ext[WIDTH-1:0];
   assign unused_hi = ^b_ext;

endmodule

// File: rtl/gray_code_counter_n.sv
// N-bit up/down Gray counter with load, optional saturation and a registered wrap pulse.
// Binary state is the core; the Gray view has its own register so it never glitches.
module gray_code_counter_n
   import gray_pkg::*;
#(
   parameter int WIDTH    = 3,
   parameter int SATURATE = 0
) (
   input logic                   clk,
   input logic                   rst,
   gray_code_counter_n_if.slave  bus
);

   localparam bit               SAT     = (SATURATE != 0);
   localparam logic [WIDTH-1:0] TERM_LO = GRAY_ZERO[WIDTH-1:0];

   logic [WIDTH-1:0]      bin_q, bin_d;
   logic [WIDTH-1:0]      gray_q, gray_d;
   logic                  wrap_q, wrap_d;
   logic [WIDTH-1:0]      load_bin;
   logic [WIDTH:0]        step_ext;
   logic [GRAY_MAX_W-1:0] step_gray_ext;
   logic                  unused_gray_hi;

   gray2bin_conv #(.WIDTH(WIDTH)) u_load_conv (
      .gray_i (bus.load_gray),
      .bin_o  (load_bin)
   );

   // Extra MSB carries the end-of-range crossing in either direction.
   assign step_ext       = bus.up ? ({1'b0, bin_q} + (WIDTH+1)'(1))
                                  : ({1'b0, bin_q} - (WIDTH+1)'(1));
   assign step_gray_ext  = bin2gray(GRAY_MAX_W'(step_ext[WIDTH-1:0]), WIDTH);
   assign unused_gray_hi = ^step_gray_ext;

   always_comb begin
      bin_d  = bin_q;
      gray_d = gray_q;
      wrap_d = 1'b0;
      if (bus.load) begin
         bin_d  = load_bin;
         gray_d = bus.load_gray;
      end else if (bus.en) begin
         if (!(step_ext[WIDTH] && SAT)) begin
            bin_d  = step_ext[WIDTH-1:0];
            gray_d = step_gray_ext[WIDTH-1:0];
            wrap_d = step_ext[WIDTH] && !SAT;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_q  <= TERM_LO;
         gray_q <= TERM_LO;
         wrap_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         gray_q <= gray_d;
         wrap_q <= wrap_d;
      end
   end

   assign bus.count     = gray_q;
   assign bus.count_bin = bin_q;
   assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_gray_code_counter_n.sv
// Bench for gray_code_counter_n: a wrapping 3-bit and a saturating 4-bit instance against an integer model.
module tb_gray_code_counter_n;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   gray_code_counter_n_if #(.WIDTH(3)) ia ();
   gray_code_counter_n_if #(.WIDTH(4)) ib ();

   gray_code_counter_n #(.WIDTH(3), .SATURATE(0)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
   gray_code_counter_n #(.WIDTH(4), .SATURATE(1)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));

   int n_cmp = 0;
   int n_mis = 0;
   int ma, mb;
   bit wa, wb;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int to_gray(input int v);
      return v ^ (v >> 1);
   endfunction

   // Decode by search over the code table rather than by bit manipulation.
   function automatic int from_gray(input int g, input int w);
      for (int b = 0; b < (1 << w); b++)
         if (to_gray(b) == g) return b;
      return -1;
   endfunction

   task automatic advance(inout int m, inout bit w, input int width, input bit sat,
                          input bit r, input bit l, input bit e, input bit u, input int lg);
      int top;
      top = (1 << width) - 1;
      w   = 1'b0;
      if (r)      m = 0;
      else if (l) m = from_gray(lg, width);
      else if (e) begin
         if (u) begin
            if (m == top) begin
               if (!sat) begin m = 0; w = 1'b1; end
            end else m = m + 1;
         end else begin
            if (m == 0) begin
               if (!sat) begin m = top; w = 1'b1; end
            end else m = m - 1;
         end
      end
   endtask

   task automatic tick();
      int  pa, pb;
      bit  sa, sb;
      pa = int'(ia.count);
      pb = int'(ib.count);
      @(posedge clk);
      sa = !rst && !ia.load && ia.en;
      sb = !rst && !ib.load && ib.en;
      advance(ma, wa, 3, 1'b0, rst, ia.load, ia.en, ia.up, int'(ia.load_gray));
      advance(mb, wb, 4, 1'b1, rst, ib.load, ib.en, ib.up, int'(ib.load_gray));
      #1;
      check_eq("a_count", 32'(ia.count), 32'(to_gray(ma)));
      check_eq("a_bin",   32'(ia.count_bin), 32'(ma));
      check_eq("a_wrap",  32'(ia.wrap), 32'(wa));
      check_eq("b_count", 32'(ib.count), 32'(to_gray(mb)));
      check_eq("b_bin",   32'(ib.count_bin), 32'(mb));
      check_eq("b_wrap",  32'(ib.wrap), 32'(wb));
      if (sa && int'(ia.count) != pa) check_eq("a_hamming", 32'($countones(int'(ia.count) ^ pa)), 32'd1);
      if (sb && int'(ib.count) != pb) check_eq("b_hamming", 32'($countones(int'(ib.count) ^ pb)), 32'd1);
   endtask

   task automatic idle_all();
      ia.en = 0; ia.up = 0; ia.load = 0; ia.load_gray = '0;
      ib.en = 0; ib.up = 0; ib.load = 0; ib.load_gray = '0;
   endtask

   initial begin
      logic [2:0] seq [9];
      seq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
      ma = 0; mb = 0; wa = 0; wb = 0;
      idle_all();
      rst = 1;

      // Reset held two edges with stepping requested.
      ia.en = 1; ia.up = 1; ib.en = 1; ib.up = 1;
      for (int k = 0; k < 2; k++) begin
         tick();
         check_eq("rst_count", 32'(ia.count), 32'd0);
         check_eq("rst_wrap",  32'(ia.wrap), 32'd0);
      end
      rst = 0;
      idle_all();

      // Up-count sequence on the 3-bit instance.
      ia.en = 1; ia.up = 1;
      for (int k = 0; k < 9; k++) begin
         tick();
         check_eq("seq_count", 32'(ia.count), 32'(seq[k]));
         check_eq("seq_wrap",  32'(ia.wrap), (k == 7) ? 32'd1 : 32'd0);
      end

      // Down-step from zero wraps to all-ones.
      ia.load = 1; ia.load_gray = 3'b000;
      tick();
      ia.load = 0; ia.en = 1; ia.up = 0;
      tick();
      check_eq("down_count", 32'(ia.count), 32'b100);
      check_eq("down_bin",   32'(ia.count_bin), 32'b111);
      check_eq("down_wrap",  32'(ia.wrap), 32'd1);
      ia.en = 0;
      tick();
      check_eq("down_wrap_clr", 32'(ia.wrap), 32'd0);

      // Load beats a concurrent step.
      ia.load = 1; ia.load_gray = 3'b110; ia.en = 1; ia.up = 1;
      tick();
      check_eq("load_count", 32'(ia.count), 32'b110);
      check_eq("load_bin",   32'(ia.count_bin), 32'b100);
      check_eq("load_wrap",  32'(ia.wrap), 32'd0);
      ia.load = 0;
      tick();
      check_eq("after_load", 32'(ia.count), 32'b111);
      idle_all();

      // Saturating 4-bit instance: climb past the top, then one step down.
      ib.load = 1; ib.load_gray = 4'b0000;
      tick();
      ib.load = 0; ib.en = 1; ib.up = 1;
      for (int k = 1; k <= 20; k++) begin
         tick();
         if (k >= 15) begin
            check_eq("sat_bin",   32'(ib.count_bin), 32'hF);
            check_eq("sat_count", 32'(ib.count), 32'b1000);
         end
         check_eq("sat_wrap", 32'(ib.wrap), 32'd0);
      end
      ib.up = 0;
      tick();
      check_eq("sat_down", 32'(ib.count_bin), 32'hE);
      idle_all();

      // Hold while disabled, then reset wins over load.
      ia.load = 1; ia.load_gray = 3'(to_gray(5));
      tick();
      ia.load = 0; ia.up = 1;
      ia.en = 0; tick(); check_eq("hold_bin", 32'(ia.count_bin), 32'd5);
      ia.en = 1; tick(); check_eq("step_bin", 32'(ia.count_bin), 32'd6);
      ia.en = 0; tick(); check_eq("hold_bin2", 32'(ia.count_bin), 32'd6);
      rst = 1; ia.load = 1; ia.load_gray = 3'b101;
      tick();
      check_eq("rst_over_load", 32'(ia.count), 32'd0);
      rst = 0;
      idle_all();

      // Randomised run on both instances.
      for (int k = 0; k < 10000; k++) begin
         rst          = ($urandom_range(0, 63) == 0);
         ia.load      = ($urandom_range(0, 15) == 0);
         ia.en        = ($urandom_range(0, 3) != 0);
         ia.up        = $urandom_range(0, 1);
         ia.load_gray = 3'($urandom);
         ib.load      = ($urandom_range(0, 15) == 0);
         ib.en        = ($urandom_range(0, 3) != 0);
         ib.up        = ($urandom_range(0, 3) != 0);
         ib.load_gray = 4'($urandom);
         tick();
         check_eq("a_coherent", 32'(ia.count), 32'(to_gray(int'(ia.count_bin))));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
